// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// stall masks, EX sequencer state encodings and the priority mask helper.
package pipe_ctrl_pkg;

  localparam logic avail   = 1'b1;
  localparam logic unavail = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    EXC_IDLE = 1'b0,
    EXC_WAIT = 1'b1
  } exc_state_t;

  // MEM outranks EX, EX outranks ID; a deeper hold covers the shallower one.
  function automatic logic [5:0] stall_mask(input logic mem, input logic ex, input logic id);
    logic [5:0] m;
    m = STALL_NONE;
    if (mem)     m = STALL_MEM;
    else if (ex) m = STALL_EX;
    else if (id) m = STALL_ID;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Fixed-latency multi-cycle EX sequencer: holds the pipe while the op runs
// and flags the result cycle. Frozen (no progress, no done) while MEM stalls.
module pipe_ctrl_mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_freeze,
  output logic o_ex_stall,
  output logic o_mc_done
);

  localparam int unsigned CW = $clog2(MC_LAT + 1);

  exc_state_t    r_state;
  exc_state_t    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EXC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (!i_freeze) begin
      case (r_state)
        EXC_IDLE: begin
          if (i_start) begin
            w_next_state = EXC_WAIT;
            w_next_cnt   = CW'(MC_LAT - 1);
          end
        end
        EXC_WAIT: begin
          if (r_cnt > CW'(1)) begin
            w_next_cnt = r_cnt - CW'(1);
          end else begin
            w_next_state = EXC_IDLE;
            w_next_cnt   = '0;
          end
        end
        default: w_next_state = EXC_IDLE;
      endcase
    end
  end

  // Start-cycle stall is asserted even when frozen; the MEM mask dominates it anyway.
  always_comb begin
    o_ex_stall = 1'b0;
    o_mc_done  = unavail;
    case (r_state)
      EXC_IDLE: o_ex_stall = i_start;
      EXC_WAIT: begin
        if (r_cnt > CW'(1)) o_ex_stall = 1'b1;
        else                o_mc_done  = i_freeze ? unavail : avail;
      end
      default: o_ex_stall = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/stall controller: stall priority mux, bounded MEM wait,
// branch flush/redirect and a stalled-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT      = 4,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_mc_start,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_done,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

  logic [WCW-1:0] r_wait_cnt;
  logic [31:0]    r_stall_cycles;
  logic           w_wait_active;
  logic           w_mem_stall;
  logic           w_timeout;
  logic           w_ex_stall;
  logic           w_mc_done;
  logic           w_flush;
  logic           w_id_stall;
  logic [5:0]     w_stall;

  assign w_wait_active = mem_req && !mem_ack;
  assign w_mem_stall   = w_wait_active && (r_wait_cnt < WCW'(MEM_TIMEOUT - 1));
  assign w_timeout     = w_wait_active && !w_mem_stall;

  // Counts consecutive MEM-wait cycles; any non-stall cycle (ack, idle, timeout) clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_wait_cnt <= '0;
    else if (w_mem_stall) r_wait_cnt <= r_wait_cnt + WCW'(1);
    else                  r_wait_cnt <= '0;
  end

  pipe_ctrl_mc_counter #(
    .MC_LAT(MC_LAT)
  ) u_mc_counter (
    .clk       (clk),
    .rst       (rst),
    .i_start   (ex_mc_start),
    .i_freeze  (w_mem_stall),
    .o_ex_stall(w_ex_stall),
    .o_mc_done (w_mc_done)
  );

  // A branch only redirects when EX advances; a flushed ID instruction cannot cause a load-use stall.
  assign w_flush    = branch_taken && !(w_mem_stall || w_ex_stall);
  assign w_id_stall = stallreq_id && !w_flush;
  assign w_stall    = stall_mask(w_mem_stall, w_ex_stall, w_id_stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_stall_cycles <= '0;
    else if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall        = rst ? STALL_NONE : w_stall;
  assign flush        = !rst && w_flush;
  assign new_pc       = (!rst && w_flush) ? branch_target : 32'd0;
  assign mc_done      = !rst && w_mc_done;
  assign mem_err      = !rst && w_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned MC_LAT      = 4;
  localparam int unsigned MEM_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        ex_mc_start = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_done;
  logic        mem_err;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: op in flight, EX cycles consumed, consecutive MEM waits, stalled-cycle total
  bit          m_busy = 1'b0;
  int          m_used = 0;
  int          m_waits = 0;
  logic [31:0] m_sc = 32'd0;

  pipe_ctrl #(.MC_LAT(MC_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_done      (mc_done),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Compare process: expected outputs derived from the current inputs and model state.
  always @(negedge clk) begin
    bit          e_mem, e_err, e_ex, e_done, e_fl;
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    if (rst) begin
      m_busy = 1'b0; m_used = 0; m_waits = 0; m_sc = 32'd0;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flags", {28'd0, flush, mc_done, mem_err, 1'b0}, 32'd0);
      chk("rst_cycles", stall_cycles, 32'd0);
    end else begin
      e_mem  = mem_req && !mem_ack && (m_waits < int'(MEM_TIMEOUT) - 1);
      e_err  = mem_req && !mem_ack && !e_mem;
      e_ex   = m_busy ? (m_used < int'(MC_LAT) - 1) : ex_mc_start;
      e_done = m_busy && (m_used == int'(MC_LAT) - 1) && !e_mem;
      e_fl   = branch_taken && !(e_mem || e_ex);
      if (e_mem)                    e_stall = 6'b011111;
      else if (e_ex)                e_stall = 6'b001111;
      else if (stallreq_id && !e_fl) e_stall = 6'b000111;
      else                          e_stall = 6'b000000;
      e_pc = e_fl ? branch_target : 32'd0;
      chk("m_stall",   32'(stall),   32'(e_stall));
      chk("m_flush",   32'(flush),   32'(e_fl));
      chk("m_new_pc",  new_pc,       e_pc);
      chk("m_mc_done", 32'(mc_done), 32'(e_done));
      chk("m_mem_err", 32'(mem_err), 32'(e_err));
      chk("m_cycles",  stall_cycles, m_sc);
      m_waits = e_mem ? m_waits + 1 : 0;
      if (!e_mem) begin
        if (m_busy) begin
          if (m_used == int'(MC_LAT) - 1) m_busy = 1'b0;
          else m_used++;
        end else if (ex_mc_start) begin
          m_busy = 1'b1;
          m_used = 1;
        end
      end
      if (e_stall[0]) m_sc = m_sc + 32'd1;
    end
  end

  // Drive one cycle of inputs after the edge, then settle to mid-cycle for literal checks.
  task automatic drv(input logic sid, input logic emc, input logic bt, input logic [31:0] bta,
                     input logic mreq, input logic mack);
    @(posedge clk); #1;
    stallreq_id = sid; ex_mc_start = emc; branch_taken = bt;
    branch_target = bta; mem_req = mreq; mem_ack = mack;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Load-use bubble
    drv(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_flush", 32'(flush), 32'd0);
    idle();
    chk("lu_cycles", stall_cycles, 32'd1);

    // Multi-cycle op
    for (int i = 1; i <= 3; i++) begin
      drv(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("mc_stall", 32'(stall), 32'h0F);
      chk("mc_nodone", 32'(mc_done), 32'd0);
    end
    drv(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("mc_done", 32'(mc_done), 32'd1);
    chk("mc_stall_end", 32'(stall), 32'd0);
    idle();
    chk("mc_done_once", 32'(mc_done), 32'd0);

    // MEM wait then ack
    for (int i = 1; i <= 2; i++) begin
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("mw_stall", 32'(stall), 32'h1F);
    end
    drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("mw_ack_stall", 32'(stall), 32'd0);
    chk("mw_ack_err", 32'(mem_err), 32'd0);
    idle();

    // MEM timeout
    for (int i = 1; i <= 7; i++) begin
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("to_stall", 32'(stall), 32'h1F);
      chk("to_noerr", 32'(mem_err), 32'd0);
    end
    drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_release", 32'(stall), 32'd0);
    idle();
    chk("to_err_pulse", 32'(mem_err), 32'd0);

    // Branch beats load-use, but not a MEM stall
    drv(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_pc", new_pc, 32'h100);
    chk("br_stall", 32'(stall), 32'd0);
    drv(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    chk("br_mem_flush", 32'(flush), 32'd0);
    chk("br_mem_pc", new_pc, 32'd0);
    chk("br_mem_stall", 32'(stall), 32'h1F);
    idle();

    // Reset during cycle 2 of a multi-cycle op
    drv(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rm_pre_stall", 32'(stall), 32'h0F);
    rst = 1'b1;
    #1;
    chk("rm_stall", 32'(stall), 32'd0);
    chk("rm_cycles", stall_cycles, 32'd0);
    chk("rm_done", 32'(mc_done), 32'd0);
    ex_mc_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("rm_no_done", 32'(mc_done), 32'd0);
    end

    // Randomized traffic; an op holds ex_mc_start while it sits in EX
    for (int i = 0; i < 3000; i++) begin
      drv(1'($urandom_range(0, 3) == 0),
          m_busy ? 1'b1 : 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 3) == 0),
          32'($urandom),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 5) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
